// File: rtl/peak_window_detector.sv
// peak_window_detector
//   Tracks the signed maximum and minimum of a decimated sample stream over one
//   symbol window. The window is framed by the shared free-running sample counter.
//   When the window closes, the block latches peak, trough and the midpoint
//   threshold, then pulses valid. If the counter wraps before the window closes,
//   the window is dropped and abort pulses.
//
//   Optional build macro: PEAK_WINDOW_POS_EN
//     defined   - peak_pos reports the in_count of the first window maximum
//     undefined - no position logic is built and peak_pos is tied to 0
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   in_count   free-running symbol sample counter (+1 per clk, wraps to 0)
//   data_in    filtered signed sample
//   peak_out   window maximum, registered
//   trough_out window minimum, registered
//   thresh_out (peak+trough)>>>1, registered, rounds toward -inf
//   valid      one-cycle pulse when peak/trough/thresh update
//   abort      one-cycle pulse when a window is abandoned
//   peak_pos   in_count of the first maximum (0 when position tracking is off)

module peak_window_detector #(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 13,
  parameter int WIN_START = 96,
  parameter int WIN_END   = 4095,
  parameter int DECIM     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CNT_W-1:0]         in_count,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [DATA_W-1:0] peak_out,
  output logic signed [DATA_W-1:0] trough_out,
  output logic signed [DATA_W-1:0] thresh_out,
  output logic                     valid,
  output logic                     abort,
  output logic [CNT_W-1:0]         peak_pos
);

  localparam logic [CNT_W-1:0] CntStart = CNT_W'(WIN_START);
  localparam logic [CNT_W-1:0] CntEnd   = CNT_W'(WIN_END);

  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DCNT_W-1:0] DcntLast  = DCNT_W'(DECIM - 1);
  // The WIN_START sample is taken on entry, so the first ACQ cycle is one
  // step into the decimation cycle (or already a sample cycle when DECIM=1).
  localparam logic [DCNT_W-1:0] DcntFirst = (DECIM == 1) ? DCNT_W'(0) : DCNT_W'(1);

  typedef enum logic [1:0] {StIdle, StAcq, StLatch, StHold} state_e;

  state_e                   state_q;
  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] min_q;
  logic [DCNT_W-1:0]        dcnt_q;
  logic                     wrap_seen_q;
  logic signed [DATA_W:0]   sum;
  logic [DCNT_W-1:0]        dcnt_next;

`ifdef PEAK_WINDOW_POS_EN
  logic [CNT_W-1:0]         pos_q;
  logic [CNT_W-1:0]         peak_pos_q;
`endif

  // One extra bit so peak+trough never overflows before the halving shift.
  assign sum       = {max_q[DATA_W-1], max_q} + {min_q[DATA_W-1], min_q};
  assign dcnt_next = (dcnt_q == DcntLast) ? '0 : dcnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      max_q       <= '0;
      min_q       <= '0;
      dcnt_q      <= '0;
      wrap_seen_q <= 1'b0;
      peak_out    <= '0;
      trough_out  <= '0;
      thresh_out  <= '0;
      valid       <= 1'b0;
      abort       <= 1'b0;
`ifdef PEAK_WINDOW_POS_EN
      pos_q       <= '0;
      peak_pos_q  <= '0;
`endif
    end else begin
      valid <= 1'b0;
      abort <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Exact match only: a window already running at reset release is skipped.
          if (in_count == CntStart) begin
            max_q   <= data_in;
            min_q   <= data_in;
            dcnt_q  <= DcntFirst;
`ifdef PEAK_WINDOW_POS_EN
            pos_q   <= in_count;
`endif
            state_q <= StAcq;
          end
        end
        StAcq: begin
          if (in_count == '0) begin
            // Counter wrapped before the window closed; keep old outputs.
            abort   <= 1'b1;
            state_q <= StIdle;
          end else begin
            if (dcnt_q == '0) begin
              // Strict compares keep the first occurrence on ties.
              if (data_in > max_q) begin
                max_q <= data_in;
`ifdef PEAK_WINDOW_POS_EN
                pos_q <= in_count;
`endif
              end
              if (data_in < min_q) begin
                min_q <= data_in;
              end
            end
            dcnt_q <= dcnt_next;
            if (in_count == CntEnd) begin
              state_q <= StLatch;
            end
          end
        end
        StLatch: begin
          peak_out    <= max_q;
          trough_out  <= min_q;
          thresh_out  <= DATA_W'(sum >>> 1);
          valid       <= 1'b1;
`ifdef PEAK_WINDOW_POS_EN
          peak_pos_q  <= pos_q;
`endif
          // With WIN_END at the counter maximum the wrap lands in this cycle,
          // so HOLD must not wait for another zero.
          wrap_seen_q <= (in_count == '0);
          state_q     <= StHold;
        end
        StHold: begin
          if (in_count == '0 || wrap_seen_q) begin
            wrap_seen_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PEAK_WINDOW_POS_EN
  assign peak_pos = peak_pos_q;
`else
  assign peak_pos = '0;
`endif

endmodule

// File: tb/tb_peak_window_detector.sv
module tb_peak_window_detector;

  localparam int DATA_W    = 16;
  localparam int CNT_W     = 13;
  localparam int WIN_START = 96;
  localparam int WIN_END   = 4095;
  localparam int DECIM     = 2;
  localparam int CNT_MOD   = 1 << CNT_W;

  typedef struct {
    bit is_abort;
    int peak;
    int trough;
    int thresh;
    int pos;
    int cnt;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [CNT_W-1:0]         in_count;
  logic signed [DATA_W-1:0] data_in;
  logic signed [DATA_W-1:0] peak_out;
  logic signed [DATA_W-1:0] trough_out;
  logic signed [DATA_W-1:0] thresh_out;
  logic                     valid;
  logic                     abort;
  logic [CNT_W-1:0]         peak_pos;

  int   errors = 0;
  int   checks = 0;
  int   samples [CNT_MOD];
  exp_t exp_q [$];
  exp_t last_exp;

  peak_window_detector #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .WIN_START(WIN_START),
    .WIN_END  (WIN_END),
    .DECIM    (DECIM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_count  (in_count),
    .data_in   (data_in),
    .peak_out  (peak_out),
    .trough_out(trough_out),
    .thresh_out(thresh_out),
    .valid     (valid),
    .abort     (abort),
    .peak_pos  (peak_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Floor of (a+b)/2 using plain integer arithmetic.
  function automatic int floor_half(input int s);
    if (s >= 0) return s / 2;
    return -((-s + 1) / 2);
  endfunction

  // Reference: scan the window sample list directly.
  function automatic exp_t model_window();
    exp_t e;
    int mx, mn, pos;
    mx  = samples[WIN_START];
    mn  = mx;
    pos = WIN_START;
    for (int c = WIN_START; c <= WIN_END; c += DECIM) begin
      if (samples[c] > mx) begin
        mx  = samples[c];
        pos = c;
      end
      if (samples[c] < mn) mn = samples[c];
    end
    e.is_abort = 1'b0;
    e.peak     = mx;
    e.trough   = mn;
    e.thresh   = floor_half(mx + mn);
`ifdef PEAK_WINDOW_POS_EN
    e.pos      = pos;
`else
    e.pos      = 0;
`endif
    e.cnt      = (WIN_END + 2) % CNT_MOD;
    return e;
  endfunction

  function automatic int rand_range(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  task automatic fill(input int prof);
    for (int c = 0; c < CNT_MOD; c++) begin
      case (prof)
        0:       samples[c] = rand_range(-32768, 32767);
        3:       samples[c] = rand_range(-100, 100);
        4:       samples[c] = -5;
        5:       samples[c] = rand_range(-3, 3);
        default: samples[c] = 0;
      endcase
    end
    if (prof == 1) begin
      samples[200] = 1000;
      samples[201] = 2000;
      samples[300] = -700;
    end else if (prof == 2) begin
      samples[94]   = 9000;
      samples[96]   = -400;
      samples[120]  = 500;
      samples[140]  = 500;
      samples[4094] = -300;
      samples[4095] = -9000;
      samples[4096] = 9000;
    end else if (prof == 3) begin
      samples[1000] = 32767;
      samples[2000] = -32768;
    end
  endtask

  task automatic drive(input int c);
    in_count = CNT_W'(c);
    data_in  = DATA_W'(samples[c]);
    @(posedge clk);
    #1;
  endtask

  // One counter revolution. abort_at >= 0 stops the revolution at that count so
  // the following revolution forces the counter to 0 mid-window.
  task automatic run_symbol(input int prof, input int abort_at, input int rst_at);
    exp_t e;
    fill(prof);
    if (abort_at >= 0) begin
      e          = last_exp;
      e.is_abort = 1'b1;
      e.cnt      = 1;
      exp_q.push_back(e);
    end else if (rst_at < 0) begin
      e = model_window();
      exp_q.push_back(e);
      last_exp = e;
    end
    for (int c = 0; c < CNT_MOD; c++) begin
      if (abort_at >= 0 && c > abort_at) break;
      if (abort_at < 0 && c > WIN_END + 5 && c < CNT_MOD - 2) continue;
      rst = (rst_at >= 0) && (c == rst_at || c == rst_at + 1);
      drive(c);
    end
    rst = 1'b0;
    if (rst_at >= 0) begin
      last_exp = '{1'b0, 0, 0, 0, 0, 0};
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_peak"},   int'(peak_out),   0);
    chk({tag, "_trough"}, int'(trough_out), 0);
    chk({tag, "_thresh"}, int'(thresh_out), 0);
    chk({tag, "_pos"},    int'(peak_pos),   0);
    chk({tag, "_valid"},  int'(valid),      0);
    chk({tag, "_abort"},  int'(abort),      0);
  endtask

  // Monitor: every valid/abort pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && (valid || abort)) begin
      if (valid && abort) begin
        chk("valid_and_abort", 1, 0);
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", int'(valid) + 2 * int'(abort), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_is_abort", int'(abort), int'(e.is_abort));
        chk("event_count",    int'(in_count), e.cnt);
        chk("peak_out",       int'(peak_out), e.peak);
        chk("trough_out",     int'(trough_out), e.trough);
        chk("thresh_out",     int'(thresh_out), e.thresh);
        chk("peak_pos",       int'(peak_pos), e.pos);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    last_exp = '{1'b0, 0, 0, 0, 0, 0};
    rst      = 1'b1;
    fill(6);
    drive(CNT_MOD - 3);
    drive(CNT_MOD - 2);
    rst = 1'b0;
    drive(CNT_MOD - 1);
    check_zero("reset");

    run_symbol(1, -1, -1);    // directed: 1000 / -700, odd-offset 2000 ignored
    run_symbol(0, 1000, -1);  // counter forced to 0 mid-window
    run_symbol(0, -1, 500);   // reset mid-window
    check_zero("mid_reset");
    run_symbol(0, -1, -1);
    run_symbol(2, -1, -1);    // ties, window edges, out-of-window values
    run_symbol(3, -1, -1);    // full-scale extremes
    run_symbol(4, -1, -1);    // constant -5
    run_symbol(5, -1, -1);    // narrow random, many ties
    run_symbol(0, -1, -1);

    fill(6);
    for (int c = 0; c < 4; c++) drive(c);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
